// File: rtl/fetch_stage_pkg.sv
// Shared fetch/decode definitions: FSM state encoding, PC arithmetic
// constants and the word-alignment helper. Decode and execute reuse
// PC_VIS_OFFSET so the architecturally visible PC is consistent.
package fetch_stage_pkg;

  localparam int unsigned XLEN = 32;

  // Sequential fetch stride and the ARM-visible PC offset (pc + 8).
  localparam logic [XLEN-1:0] PC_STEP       = XLEN'(4);
  localparam logic [XLEN-1:0] PC_VIS_OFFSET = XLEN'(8);

  // Fetch control FSM: one idle BOOT cycle, normal RUN, and frozen HALT.
  typedef enum logic [1:0] {
    BOOT = 2'd0,
    RUN  = 2'd1,
    HALT = 2'd2
  } fetch_state_t;

  // Force a byte address onto a word boundary.
  function automatic logic [XLEN-1:0] align_pc(input logic [XLEN-1:0] addr);
    return addr & ~(XLEN'(3));
  endfunction

endpackage

// File: rtl/fetch_stage_fd.sv
// fd_reg: fetch/decode pipeline register with valid bit.
// Priority per cycle: flush > load > consume > hold.
//   clk, rst      : clock, asynchronous active-high reset
//   i_flush       : discard contents (valid <- 0), payload kept
//   i_load        : capture a new instruction, valid <- 1
//   i_consume     : downstream took the word with nothing to replace it
//   i_instr/i_pc/i_pc_plus8 : payload to capture on load
//   o_valid/o_instr/o_pc/o_pc_plus8 : registered contents
module fd_reg
  import fetch_stage_pkg::*;
(
  input  logic            clk,
  input  logic            rst,
  input  logic            i_flush,
  input  logic            i_load,
  input  logic            i_consume,
  input  logic [XLEN-1:0] i_instr,
  input  logic [XLEN-1:0] i_pc,
  input  logic [XLEN-1:0] i_pc_plus8,
  output logic            o_valid,
  output logic [XLEN-1:0] o_instr,
  output logic [XLEN-1:0] o_pc,
  output logic [XLEN-1:0] o_pc_plus8
);

  logic            r_valid;
  logic [XLEN-1:0] r_instr;
  logic [XLEN-1:0] r_pc;
  logic [XLEN-1:0] r_pc_plus8;

  // Payload only changes on load, so it is stable whenever valid is held.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_valid    <= 1'b0;
      r_instr    <= '0;
      r_pc       <= '0;
      r_pc_plus8 <= PC_VIS_OFFSET;
    end else if (i_flush) begin
      r_valid <= 1'b0;
    end else if (i_load) begin
      r_valid    <= 1'b1;
      r_instr    <= i_instr;
      r_pc       <= i_pc;
      r_pc_plus8 <= i_pc_plus8;
    end else if (i_consume) begin
      r_valid <= 1'b0;
    end
  end

  assign o_valid    = r_valid;
  assign o_instr    = r_instr;
  assign o_pc       = r_pc;
  assign o_pc_plus8 = r_pc_plus8;

endmodule

// File: rtl/fetch_stage.sv
// fetch_stage: owns the program counter, drives the asynchronous
// instruction memory and fills the F/D register for decode.
//   RESET_PC        : PC after reset, must be word aligned
//   clk, rst        : clock, asynchronous active-high reset
//   imem_addr       : fetch address (equal to the PC register)
//   imem_instr      : word returned combinationally for imem_addr
//   id_valid/id_ready : F/D handshake towards decode
//   id_instr/id_pc/id_pc_plus8 : F/D payload
//   redirect/redirect_target   : taken branch / flush from execute
//   halt            : stop fetching after the current cycle
//   fetch_count     : completed, non-flushed F/D transfers (wraps)
module fetch_stage
  import fetch_stage_pkg::*;
#(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        rst,
  output logic [31:0] imem_addr,
  input  logic [31:0] imem_instr,
  output logic        id_valid,
  input  logic        id_ready,
  output logic [31:0] id_instr,
  output logic [31:0] id_pc,
  output logic [31:0] id_pc_plus8,
  input  logic        redirect,
  input  logic [31:0] redirect_target,
  input  logic        halt,
  output logic [31:0] fetch_count
);

  fetch_state_t    r_state;
  fetch_state_t    w_state_next;
  logic [XLEN-1:0] r_pc;
  logic [XLEN-1:0] w_pc_next;
  logic [XLEN-1:0] r_fetch_count;
  logic            w_adv;
  logic            w_xfer;
  logic            w_fd_load;

  // A transfer is the decode handshake; a redirect in the same cycle voids it.
  assign w_xfer    = id_valid & id_ready;
  assign w_fd_load = w_adv & ~redirect;

  // FSM state register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= BOOT;
    end else begin
      r_state <= w_state_next;
    end
  end

  // Next state, advance decision and next PC; redirect always dominates.
  always_comb begin
    w_state_next = r_state;
    w_adv        = 1'b0;
    w_pc_next    = r_pc;

    case (r_state)
      BOOT: begin
        if (redirect) begin
          w_state_next = RUN;
        end else if (halt) begin
          w_state_next = HALT;
        end else begin
          w_state_next = RUN;
        end
      end
      RUN: begin
        w_adv = ~id_valid | id_ready;
        if (halt && !redirect) begin
          w_state_next = HALT;
        end
      end
      HALT: begin
        if (redirect || !halt) begin
          w_state_next = RUN;
        end
      end
      default: begin
        w_state_next = BOOT;
      end
    endcase

    if (redirect) begin
      w_pc_next = align_pc(redirect_target);
    end else if (w_adv) begin
      w_pc_next = r_pc + PC_STEP;
    end
  end

  // Program counter.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_pc <= RESET_PC;
    end else begin
      r_pc <= w_pc_next;
    end
  end

  // Retired-fetch counter, wraps naturally at 2^32.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_fetch_count <= '0;
    end else if (w_xfer && !redirect) begin
      r_fetch_count <= r_fetch_count + XLEN'(1);
    end
  end

  // The memory is asynchronous: the word for r_pc is captured on the same edge.
  fd_reg u_fd_reg (
    .clk        (clk),
    .rst        (rst),
    .i_flush    (redirect),
    .i_load     (w_fd_load),
    .i_consume  (w_xfer),
    .i_instr    (imem_instr),
    .i_pc       (r_pc),
    .i_pc_plus8 (r_pc + PC_VIS_OFFSET),
    .o_valid    (id_valid),
    .o_instr    (id_instr),
    .o_pc       (id_pc),
    .o_pc_plus8 (id_pc_plus8)
  );

  assign imem_addr   = r_pc;
  assign fetch_count = r_fetch_count;

endmodule

// File: tb/tb_fetch_stage.sv
// Self-checking bench for fetch_stage: scoreboard of expected transfer
// addresses plus directed checks for reset, stall, redirect, halt, wrap.
module tb_fetch_stage;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [31:0] imem_addr;
  logic [31:0] imem_instr;
  logic        id_valid;
  logic        id_ready = 1'b0;
  logic [31:0] id_instr;
  logic [31:0] id_pc;
  logic [31:0] id_pc_plus8;
  logic        redirect = 1'b0;
  logic [31:0] redirect_target = 32'h0;
  logic        halt = 1'b0;
  logic [31:0] fetch_count;

  // Second instance for PC wrap-around.
  logic        rst_w = 1'b1;
  logic [31:0] wr_addr;
  logic [31:0] wr_instr_in;
  logic        wr_valid;
  logic        wr_ready = 1'b1;
  logic [31:0] wr_instr;
  logic [31:0] wr_pc;
  logic [31:0] wr_plus8;
  logic        wr_redirect = 1'b0;
  logic [31:0] wr_target = 32'h0;
  logic        wr_halt = 1'b0;
  logic [31:0] wr_count;

  int unsigned n_checks = 0;
  int unsigned n_errors = 0;
  logic [31:0] exp_q[$];
  logic [31:0] sb_pc;

  always #5 clk = ~clk;

  // Instruction memory contents: distinct word per address.
  function automatic logic [31:0] imem_word(input logic [31:0] a);
    return {a[15:0] ^ 16'hA5C3, ~a[17:2]};
  endfunction

  assign imem_instr  = imem_word(imem_addr);
  assign wr_instr_in = imem_word(wr_addr);

  fetch_stage #(.RESET_PC(32'h0000_0000)) dut (
    .clk             (clk),
    .rst             (rst),
    .imem_addr       (imem_addr),
    .imem_instr      (imem_instr),
    .id_valid        (id_valid),
    .id_ready        (id_ready),
    .id_instr        (id_instr),
    .id_pc           (id_pc),
    .id_pc_plus8     (id_pc_plus8),
    .redirect        (redirect),
    .redirect_target (redirect_target),
    .halt            (halt),
    .fetch_count     (fetch_count)
  );

  fetch_stage #(.RESET_PC(32'hFFFF_FFF8)) dut_wrap (
    .clk             (clk),
    .rst             (rst_w),
    .imem_addr       (wr_addr),
    .imem_instr      (wr_instr_in),
    .id_valid        (wr_valid),
    .id_ready        (wr_ready),
    .id_instr        (wr_instr),
    .id_pc           (wr_pc),
    .id_pc_plus8     (wr_plus8),
    .redirect        (wr_redirect),
    .redirect_target (wr_target),
    .halt            (wr_halt),
    .fetch_count     (wr_count)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Drive inputs for the next edge, then step just past it.
  task automatic cyc(input logic rdy, input logic rdr, input logic [31:0] tgt, input logic hlt);
    id_ready        = rdy;
    redirect        = rdr;
    redirect_target = tgt;
    halt            = hlt;
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst             = 1'b1;
    id_ready        = 1'b0;
    redirect        = 1'b0;
    redirect_target = 32'h0;
    halt            = 1'b0;
    @(posedge clk);
    #1;
    check("rst_valid", 32'(id_valid), 32'd0);
    check("rst_instr", id_instr, 32'h0);
    check("rst_pc", id_pc, 32'h0);
    check("rst_plus8", id_pc_plus8, 32'h8);
    check("rst_count", fetch_count, 32'h0);
    check("rst_addr", imem_addr, 32'h0);
    rst = 1'b0;
  endtask

  // Scoreboard: every handshake that survives (no redirect) pops one expectation.
  always @(negedge clk) begin
    if (!rst && id_valid && id_ready && !redirect) begin
      if (exp_q.size() == 0) begin
        check("sb_underflow", 32'(exp_q.size()), 32'd1);
      end else begin
        sb_pc = exp_q.pop_front();
        check("xfer_pc", id_pc, sb_pc);
        check("xfer_instr", id_instr, imem_word(sb_pc));
        check("xfer_plus8", id_pc_plus8, sb_pc + 32'd8);
      end
    end
  end

  initial begin
    // Reset and stream.
    do_reset();
    exp_q.push_back(32'h0);
    exp_q.push_back(32'h4);
    exp_q.push_back(32'h8);
    exp_q.push_back(32'hC);
    cyc(1'b1, 1'b0, 32'h0, 1'b0);
    check("boot_valid", 32'(id_valid), 32'd0);
    cyc(1'b1, 1'b0, 32'h0, 1'b0);
    check("first_valid", 32'(id_valid), 32'd1);
    check("first_pc", id_pc, 32'h0);
    check("first_addr", imem_addr, 32'h4);
    for (int i = 0; i < 4; i++) cyc(1'b1, 1'b0, 32'h0, 1'b0);
    check("stream_count", fetch_count, 32'd4);
    check("stream_pc", id_pc, 32'h10);

    // Back-pressure while id_pc = 8.
    do_reset();
    exp_q.push_back(32'h0);
    exp_q.push_back(32'h4);
    for (int i = 0; i < 4; i++) cyc(1'b1, 1'b0, 32'h0, 1'b0);
    check("bp_pre_pc", id_pc, 32'h8);
    for (int i = 0; i < 3; i++) begin
      cyc(1'b0, 1'b0, 32'h0, 1'b0);
      check("bp_valid", 32'(id_valid), 32'd1);
      check("bp_pc", id_pc, 32'h8);
      check("bp_instr", id_instr, imem_word(32'h8));
      check("bp_addr", imem_addr, 32'hC);
    end
    exp_q.push_back(32'h8);
    cyc(1'b1, 1'b0, 32'h0, 1'b0);
    check("bp_release_pc", id_pc, 32'hC);
    exp_q.push_back(32'hC);
    cyc(1'b1, 1'b0, 32'h0, 1'b0);
    check("bp_count", fetch_count, 32'd4);

    // Redirect while id_pc = 4; the flushed word is not counted.
    do_reset();
    exp_q.push_back(32'h0);
    for (int i = 0; i < 3; i++) cyc(1'b1, 1'b0, 32'h0, 1'b0);
    check("rd_pre_pc", id_pc, 32'h4);
    cyc(1'b1, 1'b1, 32'h0000_0023, 1'b0);
    check("rd_valid", 32'(id_valid), 32'd0);
    check("rd_addr", imem_addr, 32'h20);
    check("rd_count", fetch_count, 32'd1);
    exp_q.push_back(32'h20);
    cyc(1'b1, 1'b0, 32'h0, 1'b0);
    check("rd_tgt_valid", 32'(id_valid), 32'd1);
    check("rd_tgt_pc", id_pc, 32'h20);

    // Halt: the in-flight fetch completes, then the stage drains and freezes.
    exp_q.push_back(32'h24);
    cyc(1'b1, 1'b0, 32'h0, 1'b1);
    check("halt_last_pc", id_pc, 32'h24);
    cyc(1'b1, 1'b0, 32'h0, 1'b1);
    check("halt_valid", 32'(id_valid), 32'd0);
    check("halt_addr", imem_addr, 32'h28);
    cyc(1'b1, 1'b0, 32'h0, 1'b1);
    check("halt_frozen_valid", 32'(id_valid), 32'd0);
    check("halt_frozen_addr", imem_addr, 32'h28);
    check("halt_count", fetch_count, 32'd3);
    cyc(1'b1, 1'b1, 32'h10, 1'b1);
    check("resume_valid", 32'(id_valid), 32'd0);
    check("resume_addr", imem_addr, 32'h10);
    cyc(1'b0, 1'b0, 32'h0, 1'b0);
    check("resume_pc", id_pc, 32'h10);
    check("resume_instr", id_instr, imem_word(32'h10));

    // Async reset pulse mid-stall, checked before the next edge.
    cyc(1'b0, 1'b0, 32'h0, 1'b0);
    check("stall_valid", 32'(id_valid), 32'd1);
    rst = 1'b1;
    #2;
    check("arst_valid", 32'(id_valid), 32'd0);
    check("arst_addr", imem_addr, 32'h0);
    check("arst_count", fetch_count, 32'd0);
    rst = 1'b0;
    @(posedge clk);
    #1;
    check("sb_drained", 32'(exp_q.size()), 32'd0);

    // PC wrap on the second instance.
    rst_w = 1'b0;
    @(posedge clk);
    #1;
    @(posedge clk);
    #1;
    check("wrap0_valid", 32'(wr_valid), 32'd1);
    check("wrap0_pc", wr_pc, 32'hFFFF_FFF8);
    check("wrap0_plus8", wr_plus8, 32'h0);
    check("wrap0_instr", wr_instr, imem_word(32'hFFFF_FFF8));
    @(posedge clk);
    #1;
    check("wrap1_pc", wr_pc, 32'hFFFF_FFFC);
    check("wrap1_plus8", wr_plus8, 32'h4);
    @(posedge clk);
    #1;
    check("wrap2_pc", wr_pc, 32'h0);
    check("wrap2_plus8", wr_plus8, 32'h8);
    check("wrap2_count", wr_count, 32'd2);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule

// File: doc/fetch_stage.md
# fetch_stage

Instruction-fetch stage that sits directly upstream of the 64-word asynchronous instruction memory and directly upstream of decode. It owns the program counter and drives the memory address. It registers the returned word into a fetch/decode pipeline register with a valid/ready handshake. It also handles branch redirects, decode back-pressure and halt, and counts retired fetches.

## Interface
Parameters:
- RESET_PC, 32'h0000_0000, PC value loaded on reset; bits [1:0] must be zero.

Ports:
- clk  in  1  rising-edge clock.
- rst  in  1  reset, asynchronous, active-high.
- imem_addr  out  32  fetch address to instruction memory; always equals pc.
- imem_instr  in  32  instruction word returned combinationally for imem_addr.
- id_valid  out  1  the F/D register holds an instruction.
- id_ready  in  1  decode accepts the F/D contents this cycle.
- id_instr  out  32  registered instruction.
- id_pc  out  32  address id_instr was fetched from.
- id_pc_plus8  out  32  id_pc + 8 (ARM-visible PC value).
- redirect  in  1  branch taken / flush request from execute.
- redirect_target  in  32  new PC; bits [1:0] are forced to 0.
- halt  in  1  stop fetching after the current cycle.
- fetch_count  out  32  number of completed transfers (id_valid & id_ready).

## Operation
- Reset values: pc = RESET_PC, state = BOOT, id_valid = 0, id_instr = 0, id_pc = 0, id_pc_plus8 = 8, fetch_count = 0.
- FSM states:
  - BOOT: one cycle, no fetch. Then to RUN, or HALT if halt = 1.
  - RUN: normal fetch.
  - HALT: no fetch; pc is frozen.
- Transitions:
  - RUN→HALT when halt = 1 and redirect = 0.
  - HALT→RUN on redirect = 1, or when halt = 0.
  - redirect in BOOT goes to RUN.
- Advance condition: adv = (state == RUN) & (!id_valid | id_ready).
- Priority per cycle: redirect > adv > hold.
  - redirect: pc ← {redirect_target[31:2], 2'b00}; id_valid ← 0. The F/D contents are discarded even if id_ready = 1. The discarded word is not counted.
  - adv (no redirect): id_instr ← imem_instr, id_pc ← pc, id_pc_plus8 ← pc + 8, id_valid ← 1, pc ← pc + 4.
  - Otherwise: pc and all F/D fields hold.
- Valid drop: if id_valid & id_ready and there is no adv (HALT or BOOT), id_valid ← 0.
- Handshake rule: while id_valid = 1 and id_ready = 0, id_instr, id_pc and id_pc_plus8 stay stable.
- fetch_count increments by 1 when id_valid & id_ready & !redirect. It wraps modulo 2^32.
- Arithmetic: all PC adds are 32-bit unsigned and wrap. For example, pc = 32'hFFFF_FFFC advances to 0, and id_pc_plus8 = 32'h0000_0004.
- Reset mid-operation: all state returns to reset values immediately, without waiting for a clock edge.

## Timing
- imem_addr is combinational from the pc register, with zero added delay.
- Fetch-to-decode latency: 1 cycle. The word at pc appears on id_instr the edge after adv.
- Steady state with id_ready = 1: one instruction per cycle.
- First id_valid = 1 occurs 2 edges after rst deasserts (BOOT, then RUN fetch).
- Redirect penalty: id_valid = 0 for the cycle after redirect. The target instruction is valid on the following edge.
- Redirect and halt together: redirect wins, and the FSM stays in (or enters) RUN.

## Structure
- A shared package holds the FSM state enum fetch_state_t (BOOT, RUN, HALT) and constants PC_STEP = 4 and PC_VIS_OFFSET = 8. Decode and execute reuse the latter.
- One natural sub-module, fd_reg: the F/D pipeline register with valid, load, flush and hold.
- The PC register, FSM and counter live in fetch_stage itself.

## Test plan
- Reset and stream: RESET_PC = 0, id_ready = 1. Expect id_pc = 0, 4, 8, 12 on consecutive cycles starting 2 edges after reset. id_instr must equal the imem word at each address, and fetch_count must be 4 after 4 transfers.
- Back-pressure: hold id_ready = 0 for 3 cycles while id_valid = 1 with id_pc = 8. Expect id_pc and id_instr stable and pc stable at 12. On release, id_pc = 12 the next cycle.
- Redirect: redirect = 1 with target 32'h0000_0023 while id_pc = 4. Expect pc = 32'h20 and id_valid = 0 for one cycle, then id_pc = 32'h20. fetch_count is not incremented for the flushed word.
- Halt: assert halt in RUN. Expect the current F/D word to complete, then id_valid = 0 with pc frozen. A redirect to 32'h10 resumes with id_pc = 32'h10.
- Wrap: RESET_PC = 32'hFFFF_FFF8. Expect id_pc = FFFF_FFF8, FFFF_FFFC, 0000_0000, with id_pc_plus8 = 0, 4, 8.
- Async reset mid-stall: pulse rst between clock edges while id_valid = 1. Expect id_valid = 0, pc = RESET_PC and fetch_count = 0 before the next edge.
